// File: rtl/alu_pkg.sv
// Shared opcode and engine-state types for the ALU with its multiply/divide engine.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_XOR   = 4'b0011,
    OP_ANDN  = 4'b0100,
    OP_ORN   = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_SLTU  = 4'b1000,
    OP_NOR   = 4'b1001,
    OP_RSV0  = 4'b1010,
    OP_RSV1  = 4'b1011,
    OP_MULTU = 4'b1100,
    OP_MULT  = 4'b1101,
    OP_DIVU  = 4'b1110,
    OP_DIV   = 4'b1111
  } alu_op_t;

  // Codes with this prefix in [3:2] drive the multiply/divide engine.
  localparam logic [1:0] OP_ENGINE_PREFIX = 2'b11;

  typedef enum logic {
    ENG_IDLE = 1'b0,
    ENG_RUN  = 1'b1
  } eng_state_t;

endpackage

// File: rtl/muldiv_engine.sv
// Iterative multiply/divide into HI/LO: one shift-add or restoring shift-subtract step per cycle,
// WIDTH+1 edges start-to-done; start is ignored unless idle, no backpressure on the result.
module muldiv_engine
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  eng_state_t       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ok;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [2*WIDTH-1:0] prod_neg;
  logic [WIDTH-1:0] fin_hi, fin_lo;

  assign a_neg = op[0] & opa[WIDTH-1];
  assign b_neg = op[0] & opb[WIDTH-1];
  assign a_mag = a_neg ? -opa : opa;
  assign b_mag = b_neg ? -opb : opb;

  // Multiply: acc holds the running upper half, quo shifts the multiplier out as product bits enter.
  assign mul_sum = {1'b0, acc_q} + ({(WIDTH+1){quo_q[0]}} & {1'b0, opb_q});

  // Divide: acc is the partial remainder, quo shifts dividend bits out and quotient bits in.
  assign div_shift = {acc_q, quo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_ok    = (div_shift >= {1'b0, opb_q});

  always_comb begin
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], quo_q[WIDTH-1:1]};
    if (is_div_q) begin
      step_hi = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {quo_q[WIDTH-2:0], div_ok};
    end
  end

  // A zero divisor leaves quotient all ones and remainder = |dividend|; only the remainder is re-signed.
  always_comb begin
    prod_neg = -{step_hi, step_lo};
    fin_hi   = step_hi;
    fin_lo   = step_lo;
    if (is_div_q) begin
      if (neg_res_q && !div0_q) fin_lo = -step_lo;
      if (neg_rem_q)            fin_hi = -step_hi;
    end else if (neg_res_q) begin
      fin_hi = prod_neg[2*WIDTH-1:WIDTH];
      fin_lo = prod_neg[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    quo_d     = quo_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      ENG_IDLE: begin
        if (start && (op[3:2] == OP_ENGINE_PREFIX)) begin
          state_d   = ENG_RUN;
          cnt_d     = CW'(WIDTH);
          acc_d     = '0;
          quo_d     = a_mag;
          opb_d     = b_mag;
          is_div_d  = op[1];
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          div0_d    = (opb == '0);
        end
      end
      ENG_RUN: begin
        acc_d = step_hi;
        quo_d = step_lo;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ENG_IDLE;
          hi_d    = fin_hi;
          lo_d    = fin_lo;
          done_d  = 1'b1;
        end
      end
      default: state_d = ENG_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ENG_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      quo_q     <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      quo_q     <= quo_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == ENG_RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/alu_muldiv.sv
// Combinational ALU (result/zero/overflow, zero latency) plus the multi-cycle HI/LO engine;
// the combinational path never stalls, the engine signals completion with a one-cycle done.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       ALUcontrol,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             start,
  output logic [WIDTH-1:0] ALUresult,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] sum_c, diff_c, result_c;
  logic             ovf_c;

  assign sum_c  = SrcA + SrcB;
  assign diff_c = SrcA - SrcB;

  always_comb begin
    result_c = '0;
    ovf_c    = 1'b0;
    case (alu_op_t'(ALUcontrol))
      OP_AND:  result_c = SrcA & SrcB;
      OP_OR:   result_c = SrcA | SrcB;
      OP_ADD: begin
        result_c = sum_c;
        ovf_c    = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum_c[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_XOR:  result_c = SrcA ^ SrcB;
      OP_ANDN: result_c = SrcA & ~SrcB;
      OP_ORN:  result_c = SrcA | ~SrcB;
      OP_SUB: begin
        result_c = diff_c;
        ovf_c    = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (diff_c[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_SLT:  result_c = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      OP_SLTU: result_c = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      OP_NOR:  result_c = ~(SrcA | SrcB);
      default: result_c = '0;
    endcase
  end

  assign ALUresult = result_c;
  assign zero      = (result_c == '0);
  assign overflow  = ovf_c;

  muldiv_engine #(.WIDTH(WIDTH)) u_engine (
    .clk   (clk),
    .reset (reset),
    .op    (ALUcontrol),
    .opa   (SrcA),
    .opb   (SrcB),
    .start (start),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed-vector bench for alu_muldiv at WIDTH=32 with hand-computed expectations.
module tb_alu_muldiv;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [3:0]       ALUcontrol = 4'b0000;
  logic [WIDTH-1:0] SrcA = '0;
  logic [WIDTH-1:0] SrcB = '0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] ALUresult;
  logic             zero;
  logic             overflow;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  int n_checks = 0;
  int n_errors = 0;

  alu_muldiv #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .ALUcontrol(ALUcontrol),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .start     (start),
    .ALUresult (ALUresult),
    .zero      (zero),
    .overflow  (overflow),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_comb(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ALUcontrol = op;
    SrcA = a;
    SrcB = b;
    #1;
  endtask

  // Launches an engine op from a point away from the rising edge and returns at the negedge where done is seen.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int  busy_cnt;
    bit  seen;
    busy_cnt = 0;
    seen = 1'b0;
    ALUcontrol = op;
    SrcA = a;
    SrcB = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) busy_cnt++;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
    check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    bit seen_done;

    // Reset state
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Combinational datapath
    set_comb(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    check("add_res", 64'(ALUresult), 64'h8000_0000);
    check("add_ovf", 64'(overflow), 64'd1);
    check("add_zero", 64'(zero), 64'd0);

    set_comb(4'b0110, 32'd5, 32'd5);
    check("sub_res", 64'(ALUresult), 64'd0);
    check("sub_zero", 64'(zero), 64'd1);
    check("sub_ovf", 64'(overflow), 64'd0);

    set_comb(4'b0110, 32'h8000_0000, 32'd1);
    check("sub_ovf_res", 64'(ALUresult), 64'h7FFF_FFFF);
    check("sub_ovf_flag", 64'(overflow), 64'd1);

    set_comb(4'b0111, 32'hFFFF_FFFF, 32'd1);
    check("slt", 64'(ALUresult), 64'd1);
    set_comb(4'b1000, 32'hFFFF_FFFF, 32'd1);
    check("sltu", 64'(ALUresult), 64'd0);
    set_comb(4'b1001, 32'd0, 32'd0);
    check("nor", 64'(ALUresult), 64'hFFFF_FFFF);
    set_comb(4'b1010, 32'h1234_5678, 32'h0F0F_0F0F);
    check("rsv_res", 64'(ALUresult), 64'd0);
    check("rsv_zero", 64'(zero), 64'd1);
    set_comb(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00);
    check("and", 64'(ALUresult), 64'h00F0_1200);
    set_comb(4'b0011, 32'hF0F0_1234, 32'h0FF0_FF00);
    check("xor", 64'(ALUresult), 64'hFF00_ED34);
    set_comb(4'b0100, 32'hF0F0_1234, 32'h0FF0_FF00);
    check("andn", 64'(ALUresult), 64'hF000_0034);
    set_comb(4'b0101, 32'h0000_0001, 32'hFFFF_FFF0);
    check("orn", 64'(ALUresult), 64'h0000_000F);
    set_comb(4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("add_neg_ovf", 64'(overflow), 64'd0);
    set_comb(4'b1101, 32'd3, 32'd7);
    check("mult_code_res", 64'(ALUresult), 64'd0);
    check("mult_code_ovf", 64'(overflow), 64'd0);

    // Engine
    run_op("mult_m3x7", 4'b1101, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    @(negedge clk);
    check("done_width", 64'(done), 64'd0);
    check("idle_after_done", 64'(busy), 64'd0);
    run_op("multu_max", 4'b1100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_minmin", 4'b1101, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("div_m7_2", 4'b1111, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_9_0", 4'b1110, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF);
    run_op("div_m9_0", 4'b1111, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);
    run_op("div_min_m1", 4'b1111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_100_7", 4'b1110, 32'd100, 32'd7, 32'd2, 32'd14);

    // Start while busy is ignored; combinational path keeps tracking inputs
    @(negedge clk);
    ALUcontrol = 4'b1110;
    SrcA = 32'd200;
    SrcB = 32'd9;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    ALUcontrol = 4'b1100;
    SrcA = 32'd50;
    SrcB = 32'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ALUcontrol = 4'b0010;
    #1;
    check("busy_add_res", 64'(ALUresult), 64'd53);
    check("busy_midrun", 64'(busy), 64'd1);
    seen_done = 1'b0;
    for (int i = 0; i < 100 && !seen_done; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("ignored_done_seen", 64'(seen_done), 64'd1);
    check("ignored_hi", 64'(hi), 64'd2);
    check("ignored_lo", 64'(lo), 64'd22);

    // Reset in the middle of a DIV
    @(negedge clk);
    ALUcontrol = 4'b1111;
    SrcA = 32'hFFFF_FF9C;
    SrcB = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("prereset_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("abort_no_done", 64'(seen_done), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised successor to the processor's single-cycle ALU. It keeps the combinational AND/OR/ADD/SUB/SLT datapath feeding the execute stage, widened to WIDTH and extended with XOR, NOR, SLTU and signed overflow. It adds an iterative multiply/divide engine that writes dedicated HI/LO registers under a start/busy/done handshake, which the control FSM uses to stall on MULT/DIV.

## Interface
- WIDTH, 32: datapath width; even, ≥ 8.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- ALUcontrol  in  4  operation select (codes below).
- SrcA  in  WIDTH  operand A.
- SrcB  in  WIDTH  operand B.
- start  in  1  launch request for a multiply/divide code.
- ALUresult  out  WIDTH  combinational result.
- zero  out  1  high when ALUresult == 0.
- overflow  out  1  signed overflow, valid for ADD/SUB only, else 0.
- busy  out  1  engine iterating.
- done  out  1  one-cycle pulse: HI/LO just updated.
- hi  out  WIDTH  HI register (product upper half / remainder).
- lo  out  WIDTH  LO register (product lower half / quotient).

## Operation
- Combinational codes:
  - 0000 A&B; 0001 A|B; 0010 A+B; 0011 A^B.
  - 0100 A&~B; 0101 A|~B; 0110 A−B.
  - 0111 SLT signed; 1000 SLTU; 1001 ~(A|B).
  - Result is modulo 2^WIDTH. SLT/SLTU return 1 or 0 in bit 0.
- Reserved codes 1010, 1011, and all engine codes: ALUresult = 0, so zero = 1.
- Engine codes:
  - 1100 MULTU; 1101 MULT.
  - 1110 DIVU; 1111 DIV.
- overflow:
  - ADD: operands have equal signs and the result sign differs.
  - SUB: operand signs differ and the result sign differs from A.
- The combinational path is independent of busy. ALUresult tracks its inputs every cycle, including while the engine runs.
- Engine states: IDLE and RUN.
  - IDLE→RUN when start=1 and ALUcontrol[3:2]=11 at a clock edge. On that edge:
    - latch the operands (signed codes latch magnitudes plus result sign flags);
    - load the counter with WIDTH.
  - start with any other code, or while busy, is ignored.
  - RUN performs one shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
  - RUN→IDLE on the edge that completes step WIDTH. That edge also:
    - applies sign correction and writes hi/lo;
    - sets done for the following cycle.
- Sign rules:
  - MULT: full 2·WIDTH-bit two's-complement product.
  - DIV: quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (no trap):
  - lo = all ones;
  - hi = dividend (DIVU), or the signed dividend unchanged (DIV).
- DIV of most-negative by −1: lo = most-negative, hi = 0.

## Timing
- Reset values: busy=0, done=0, hi=0, lo=0, state IDLE, counter 0. Reset during RUN aborts the operation with no hi/lo write.
- Acceptance edge E0 → busy=1 in the cycles after E0 … E(WIDTH−1).
- At edge E_WIDTH: hi/lo are valid, busy=0, done=1 for exactly one cycle.
- Total latency: WIDTH+1 edges from the start sample to the end of done.
- A new start is accepted on the edge that ends a done cycle (back-to-back). Throughput: one operation per WIDTH+1 cycles.
- hi/lo hold their value except on the completing edge.
- Operand changes during RUN have no effect on the engine.

## Structure
- Package alu_pkg:
  - alu_op_t enum (4-bit codes above);
  - localparam OP_ENGINE_PREFIX = 2'b11;
  - engine state typedef.
- Sub-module muldiv_engine: owns the FSM, counter, operand/accumulator registers and hi/lo.
- The top level holds the combinational datapath, zero and overflow.

## Test plan
- WIDTH=32, ADD 0x7FFFFFFF+1 → ALUresult 0x80000000, overflow=1, zero=0; SUB 5−5 → 0, zero=1, overflow=0.
- SLT 0xFFFFFFFF,1 → 1; SLTU same operands → 0; NOR 0,0 → 0xFFFFFFFF; code 1010 → 0, zero=1.
- MULT −3×7 with start pulse:
  - busy for 32 cycles;
  - done in cycle 33;
  - hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 9/0 → lo=0xFFFFFFFF, hi=9.
- DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- Start re-asserted while busy is ignored:
  - the result matches the first operands;
  - asserting reset at cycle 10 of a DIV → busy=0, hi=lo=0 immediately, and no done pulse.
